// File: rtl/baccarat_hand_datapath_if.sv
// Card/score bus between the baccarat hand datapath (slave) and the
// statemachine (master) that drives the deal and load strobes.
interface baccarat_hand_datapath_if #(
    parameter int CARD_W = 4
);
    logic              deal_en;
    logic              load_pcard1;
    logic              load_pcard2;
    logic              load_pcard3;
    logic              load_dcard1;
    logic              load_dcard2;
    logic              load_dcard3;
    logic [CARD_W-1:0] new_card;
    logic [CARD_W-1:0] pcard1;
    logic [CARD_W-1:0] pcard2;
    logic [CARD_W-1:0] pcard3;
    logic [CARD_W-1:0] dcard1;
    logic [CARD_W-1:0] dcard2;
    logic [CARD_W-1:0] dcard3;
    logic [CARD_W-1:0] pscore;
    logic [CARD_W-1:0] dscore;
    logic [1:0]        pcount;
    logic [1:0]        dcount;
    logic              pnatural;
    logic              dnatural;

    modport master (
        output deal_en, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3,
        input  new_card, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
               pscore, dscore, pcount, dcount, pnatural, dnatural
    );

    modport slave (
        input  deal_en, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3,
        output new_card, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
               pscore, dscore, pcount, dcount, pnatural, dnatural
    );
endinterface

// File: rtl/baccarat_hand_datapath.sv
// Baccarat hand datapath: deal counter, six card slots, and combinational
// score / count / natural-hand decode for player and dealer.
module baccarat_hand_datapath #(
    parameter int CARD_W   = 4,
    parameter int CARD_MAX = 13
) (
    input  logic                     slow_clock,
    input  logic                     resetb,
    baccarat_hand_datapath_if.slave  bus
);

    // Slots 0..2 are player cards 1..3, slots 3..5 dealer cards 1..3.
    logic [CARD_W-1:0] card_q [6];
    logic [CARD_W-1:0] card_d [6];
    logic [CARD_W-1:0] new_card_q;
    logic [CARD_W-1:0] new_card_d;
    logic [5:0]        load;

    function automatic logic [4:0] card_value(input logic [CARD_W-1:0] c);
        if (c >= CARD_W'(1) && c <= CARD_W'(9)) begin
            return 5'(c);
        end
        return 5'd0;
    endfunction

    // Sum of three values is at most 27, so two conditional subtractions give mod 10.
    function automatic logic [CARD_W-1:0] hand_score(input logic [CARD_W-1:0] a,
                                                      input logic [CARD_W-1:0] b,
                                                      input logic [CARD_W-1:0] c);
        logic [4:0] sum;
        sum = card_value(a) + card_value(b) + card_value(c);
        if (sum >= 5'd20) begin
            sum = sum - 5'd20;
        end else if (sum >= 5'd10) begin
            sum = sum - 5'd10;
        end
        return CARD_W'(sum);
    endfunction

    function automatic logic [1:0] hand_count(input logic [CARD_W-1:0] a,
                                               input logic [CARD_W-1:0] b,
                                               input logic [CARD_W-1:0] c);
        return {1'b0, a != '0} + {1'b0, b != '0} + {1'b0, c != '0};
    endfunction

    assign load = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                   bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};

    always_comb begin
        new_card_d = new_card_q;
        if (bus.deal_en) begin
            new_card_d = (new_card_q >= CARD_W'(CARD_MAX)) ? CARD_W'(1)
                                                           : new_card_q + 1'b1;
        end
    end

    // All slots capture the pre-advance counter value; no arbitration between loads.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            card_d[i] = load[i] ? new_card_q : card_q[i];
        end
    end

    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            new_card_q <= CARD_W'(1);
            for (int i = 0; i < 6; i++) begin
                card_q[i] <= '0;
            end
        end else begin
            new_card_q <= new_card_d;
            for (int i = 0; i < 6; i++) begin
                card_q[i] <= card_d[i];
            end
        end
    end

    assign bus.new_card = new_card_q;
    assign bus.pcard1   = card_q[0];
    assign bus.pcard2   = card_q[1];
    assign bus.pcard3   = card_q[2];
    assign bus.dcard1   = card_q[3];
    assign bus.dcard2   = card_q[4];
    assign bus.dcard3   = card_q[5];

    assign bus.pscore = hand_score(card_q[0], card_q[1], card_q[2]);
    assign bus.dscore = hand_score(card_q[3], card_q[4], card_q[5]);
    assign bus.pcount = hand_count(card_q[0], card_q[1], card_q[2]);
    assign bus.dcount = hand_count(card_q[3], card_q[4], card_q[5]);

    // A natural needs exactly two cards and an empty third slot.
    assign bus.pnatural = (bus.pcount == 2'd2) && (bus.pscore >= CARD_W'(8)) && (card_q[2] == '0);
    assign bus.dnatural = (bus.dcount == 2'd2) && (bus.dscore >= CARD_W'(8)) && (card_q[5] == '0);

endmodule

// File: tb/tb_baccarat_hand_datapath.sv
// Scoreboard bench for baccarat_hand_datapath: directed hands followed by
// random deal/load/reset traffic, checked against a rank/value model.
module tb_baccarat_hand_datapath;

    typedef struct {
        int nc;
        int p1, p2, p3, d1, d2, d3;
        int ps, ds, pc, dc, pn, dn;
    } exp_t;

    logic slow_clock = 1'b0;
    logic resetb;

    baccarat_hand_datapath_if #(.CARD_W(4)) bus ();

    baccarat_hand_datapath #(.CARD_W(4), .CARD_MAX(13)) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .bus        (bus)
    );

    always #5 slow_clock = ~slow_clock;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: current deal card and six ranks (0 = empty).
    int m_nc;
    int m_card[6];

    function automatic int val(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        int pcnt, dcnt;
        e.nc = m_nc;
        e.p1 = m_card[0]; e.p2 = m_card[1]; e.p3 = m_card[2];
        e.d1 = m_card[3]; e.d2 = m_card[4]; e.d3 = m_card[5];
        e.ps = (val(e.p1) + val(e.p2) + val(e.p3)) % 10;
        e.ds = (val(e.d1) + val(e.d2) + val(e.d3)) % 10;
        pcnt = 0; dcnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (m_card[i] != 0) pcnt++;
            if (m_card[i+3] != 0) dcnt++;
        end
        e.pc = pcnt; e.dc = dcnt;
        e.pn = (pcnt == 2 && e.ps >= 8 && e.p3 == 0) ? 1 : 0;
        e.dn = (dcnt == 2 && e.ds >= 8 && e.d3 == 0) ? 1 : 0;
        return e;
    endfunction

    // Drive one cycle of inputs, advance the model, queue the post-edge state.
    task automatic cycle(input bit deal, input bit [5:0] ld, input bit rst);
        resetb          = rst;
        bus.deal_en     = deal;
        bus.load_pcard1 = ld[0];
        bus.load_pcard2 = ld[1];
        bus.load_pcard3 = ld[2];
        bus.load_dcard1 = ld[3];
        bus.load_dcard2 = ld[4];
        bus.load_dcard3 = ld[5];
        if (rst) begin
            m_nc = 1;
            for (int i = 0; i < 6; i++) m_card[i] = 0;
        end else begin
            for (int i = 0; i < 6; i++) if (ld[i]) m_card[i] = m_nc;
            if (deal) m_nc = (m_nc == 13) ? 1 : m_nc + 1;
        end
        sbq.push_back(snapshot());
        @(posedge slow_clock);
        #1;
    endtask

    task automatic deal_to(input int v);
        for (int k = 0; k < 14 && m_nc != v; k++) cycle(1'b1, 6'b0, 1'b0);
    endtask

    task automatic load_card(input int v, input bit [5:0] ld);
        deal_to(v);
        cycle(1'b0, ld, 1'b0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle's outputs are compared against the queued state.
    initial begin
        exp_t e;
        forever begin
            @(negedge slow_clock);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("new_card", int'(bus.new_card), e.nc);
                chk("pcard1",   int'(bus.pcard1),   e.p1);
                chk("pcard2",   int'(bus.pcard2),   e.p2);
                chk("pcard3",   int'(bus.pcard3),   e.p3);
                chk("dcard1",   int'(bus.dcard1),   e.d1);
                chk("dcard2",   int'(bus.dcard2),   e.d2);
                chk("dcard3",   int'(bus.dcard3),   e.d3);
                chk("pscore",   int'(bus.pscore),   e.ps);
                chk("dscore",   int'(bus.dscore),   e.ds);
                chk("pcount",   int'(bus.pcount),   e.pc);
                chk("dcount",   int'(bus.dcount),   e.dc);
                chk("pnatural", int'(bus.pnatural), e.pn);
                chk("dnatural", int'(bus.dnatural), e.dn);
            end
        end
    end

    initial begin
        bit [5:0] ld;
        m_nc = 1;
        for (int i = 0; i < 6; i++) m_card[i] = 0;
        @(negedge slow_clock);

        // Reset, then a full wrap of the deal counter.
        cycle(1'b0, 6'b0, 1'b1);
        for (int i = 0; i < 15; i++) cycle(1'b1, 6'b0, 1'b0);
        cycle(1'b1, 6'b0, 1'b1);

        // Player 7 then 12.
        load_card(7, 6'b000001);
        load_card(12, 6'b000010);

        // Player natural 5+4, then third card 3.
        cycle(1'b0, 6'b0, 1'b1);
        load_card(5, 6'b000001);
        load_card(4, 6'b000010);
        load_card(3, 6'b000100);

        // Dealer 9,9,9 then 13,10 with slot 3 cleared by reset.
        load_card(9, 6'b111000);
        cycle(1'b0, 6'b0, 1'b1);
        load_card(13, 6'b001000);
        load_card(10, 6'b010000);
        load_card(8, 6'b000011);

        // Simultaneous loads at 6, then overwrite pcard1 with 11.
        cycle(1'b0, 6'b0, 1'b1);
        load_card(6, 6'b001001);
        load_card(11, 6'b000001);

        // Loads and deal in the reset cycle are discarded.
        load_card(9, 6'b000110);
        cycle(1'b1, 6'b111111, 1'b1);
        cycle(1'b0, 6'b0, 1'b0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            ld = '0;
            for (int i = 0; i < 6; i++) ld[i] = ($urandom_range(0, 5) == 0);
            cycle(1'($urandom_range(0, 1)), ld, ($urandom_range(0, 39) == 0));
        end

        for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge slow_clock);
        @(negedge slow_clock);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
